proc_core16: RTL and testbench
==============================

// Module: proc_core16
// PURPOSE
//  16-bit multi-cycle accumulator-free RISC core with 8x16 register file and NZCV flags.
//  Fetches from port 0 and loads/stores via port 1 of a shared 2-port 16x128 synchronous RAM.
//  The RAM is ram_rw_2p_16x128, external to this block; both ports may address one array.
//  Sits at the top of the processor, with one RAM as its only neighbour.
// PARAMETERS
//  AW  7   address width (PC and data address, 128 words)
//  DW  16  data and instruction width
// PORTS
//  clk               in   1   single clock, rising edge
//  rst_n             in   1   asynchronous active-low reset
//  start             in   1   level; leaves IDLE when sampled high
//  data_in           in   16  instruction word from program RAM dout0
//  data_ram_dout     in   16  load data from RAM dout1
//  result            out  16  last value written to the register file
//  zero/negative     out  1   Z/N flags
//  overflow/carry    out  1   V/C flags
//  pc                out  7   program address (RAM addr0)
//  prog_ram_read_en  out  1   RAM read_en0
//  data_ram_read_en  out  1   RAM read_en1
//  write_ram_en      out  1   RAM write_en1
//  data_ram_din      out  16  store data (RAM din1)
//  data_ram_addr     out  7   load/store address (RAM addr1)
// BEHAVIOUR
//  Reset (async, rst_n=0): all outputs, flags, pc, IR and r0..r7 = 0; state=IDLE.
//  RAM is synchronous: read data valid one clk after read_en with address.
//  FSM: IDLE -start-> FETCH -> DECODE -> EXEC -> (LD: MEM) -> FETCH; HALT -> HALTED (stays until reset).
//   FETCH: prog_ram_read_en=1, addr0=pc.
//   DECODE: IR <= data_in.
//   EXEC: run the instruction, update pc (pc+1 mod 128, wraps 127->0, or branch target).
//   MEM: rd <= data_ram_dout.
//  start is ignored outside IDLE. ALU ops take 3 cycles; LD takes 4.
//  Encoding: op=IR[15:12], rd=IR[11:9], rs=IR[8:6], rt=IR[5:3], imm9=IR[8:0], tgt=IR[6:0].
//   0 NOP | 1 ADD rd=rs+rt | 2 SUB rd=rs-rt | 3 AND | 4 OR | 5 XOR
//   6 NOT rd=~rs | 7 SHL rd=rs<<1 | 8 SHR rd=rs>>1 (logical)
//   9 LDI rd=sext(imm9)
//   A LD  rd=mem[rs[6:0]]: EXEC drives data_ram_read_en=1, addr1=rs[6:0]
//   B ST  mem[rs[6:0]]=rd: EXEC drives write_ram_en=1, din1=rd
//   C JMP pc=tgt | D BZ if Z pc=tgt | E BNZ if !Z pc=tgt | F HALT (pc frozen)
//  Flags update only on ops 1-8; Z=(res==0), N=res[15].
//   ADD: C=carry-out; V=signed overflow.
//   SUB: C=1 when no borrow (rs>=rt unsigned); V=signed overflow.
//   Logic and shift ops: C=shifted-out bit for SHL/SHR, else 0; V=0.
//  LDI/LD/ST/branches leave flags unchanged. result updates on every register write.
//  Register read and write in the same EXEC: read sees the old value (write at clk edge).
//  Enables are 1-cycle pulses and never overlap. write_ram_en and data_ram_read_en are never both high.
//  Reset mid-instruction aborts immediately, with no RAM write after rst_n falls.
// STRUCTURE
//  Shared package proc16_pkg: opcode localparams, state enum (IDLE, FETCH, DECODE, EXEC, MEM, HALTED), field slices.
//  Sub-module reg_file_8x16, instance reg_file_8x16_1, storage named r0..r7 (bench probes these).
//   2 async read ports, 1 sync write port, async reset.
// TESTING
//  1. Reset, then start=1; check first FETCH at pc=0 and pc increments every 3 cycles on NOPs.
//  2. LDI r1,5; LDI r2,-3; ADD r3,r1,r2 -> r3=2, C=1, V=0, Z=0, N=0, result=2.
//  3. LDI r1,0x0FF; SUB r4,r1,r1 -> r4=0, Z=1, C=1. Then LDI r5,1; SHL chain to 0x8000 -> N=1.
//  4. ST r3 @ addr 100; LD r6 @ 100 -> write_ram_en pulse addr1=100 din=2; r6=2 four cycles later.
//  5. BZ taken/not taken and JMP to 9 -> pc==9. Bench dumps r0..r7 and expects the listed values.
//  6. HALT -> pc frozen, no enables for 20 cycles. Assert rst_n=0 mid-LD -> all outputs 0 immediately.

Source files
------------

// File: rtl/proc16_pkg.sv
// Shared definitions for the 16-bit multi-cycle core: opcodes, FSM states,
// instruction field slices and the combinational ALU.
package proc16_pkg;

    localparam int unsigned PcW   = 7;
    localparam int unsigned WordW = 16;
    localparam int unsigned RegAw = 3;

    localparam logic [3:0] OpNop  = 4'h0;
    localparam logic [3:0] OpAdd  = 4'h1;
    localparam logic [3:0] OpSub  = 4'h2;
    localparam logic [3:0] OpAnd  = 4'h3;
    localparam logic [3:0] OpOr   = 4'h4;
    localparam logic [3:0] OpXor  = 4'h5;
    localparam logic [3:0] OpNot  = 4'h6;
    localparam logic [3:0] OpShl  = 4'h7;
    localparam logic [3:0] OpShr  = 4'h8;
    localparam logic [3:0] OpLdi  = 4'h9;
    localparam logic [3:0] OpLd   = 4'hA;
    localparam logic [3:0] OpSt   = 4'hB;
    localparam logic [3:0] OpJmp  = 4'hC;
    localparam logic [3:0] OpBz   = 4'hD;
    localparam logic [3:0] OpBnz  = 4'hE;
    localparam logic [3:0] OpHalt = 4'hF;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StDecode,
        StExec,
        StMem,
        StHalted
    } state_e;

    typedef struct packed {
        logic [WordW-1:0] res;
        logic             n;
        logic             z;
        logic             c;
        logic             v;
    } alu_out_t;

    function automatic logic [3:0] ir_op(input logic [WordW-1:0] ir);
        return ir[15:12];
    endfunction

    function automatic logic [RegAw-1:0] ir_rd(input logic [WordW-1:0] ir);
        return ir[11:9];
    endfunction

    function automatic logic [RegAw-1:0] ir_rs(input logic [WordW-1:0] ir);
        return ir[8:6];
    endfunction

    function automatic logic [RegAw-1:0] ir_rt(input logic [WordW-1:0] ir);
        return ir[5:3];
    endfunction

    function automatic logic [WordW-1:0] ir_imm9_sext(input logic [WordW-1:0] ir);
        return {{7{ir[8]}}, ir[8:0]};
    endfunction

    function automatic logic [PcW-1:0] ir_tgt(input logic [WordW-1:0] ir);
        return ir[6:0];
    endfunction

    function automatic logic is_alu_op(input logic [3:0] op);
        return (op >= OpAdd) && (op <= OpShr);
    endfunction

    // SUB is a + ~b + 1 so the carry-out reads as "no borrow".
    function automatic alu_out_t alu_exec(input logic [3:0]       op,
                                          input logic [WordW-1:0] a,
                                          input logic [WordW-1:0] b);
        alu_out_t    o;
        logic [16:0] sum;
        o   = '0;
        sum = '0;
        case (op)
            OpAdd: begin
                sum   = {1'b0, a} + {1'b0, b};
                o.res = sum[15:0];
                o.c   = sum[16];
                o.v   = (a[15] == b[15]) && (o.res[15] != a[15]);
            end
            OpSub: begin
                sum   = {1'b0, a} + {1'b0, ~b} + 17'd1;
                o.res = sum[15:0];
                o.c   = sum[16];
                o.v   = (a[15] != b[15]) && (o.res[15] != a[15]);
            end
            OpAnd: o.res = a & b;
            OpOr:  o.res = a | b;
            OpXor: o.res = a ^ b;
            OpNot: o.res = ~a;
            OpShl: begin
                o.res = {a[14:0], 1'b0};
                o.c   = a[15];
            end
            OpShr: begin
                o.res = {1'b0, a[15:1]};
                o.c   = a[0];
            end
            default: o.res = '0;
        endcase
        o.z = (o.res == '0);
        o.n = o.res[15];
        return o;
    endfunction

endpackage

// File: rtl/reg_file_8x16.sv
// Eight 16-bit registers: two asynchronous read ports, one synchronous write port.
module reg_file_8x16
    import proc16_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [RegAw-1:0] raddr_a,
    input  logic [RegAw-1:0] raddr_b,
    output logic [WordW-1:0] rdata_a,
    output logic [WordW-1:0] rdata_b,
    input  logic             we,
    input  logic [RegAw-1:0] waddr,
    input  logic [WordW-1:0] wdata
);

    logic [WordW-1:0] r0, r1, r2, r3, r4, r5, r6, r7;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r0 <= '0;
            r1 <= '0;
            r2 <= '0;
            r3 <= '0;
            r4 <= '0;
            r5 <= '0;
            r6 <= '0;
            r7 <= '0;
        end else if (we) begin
            case (waddr)
                3'd0: r0 <= wdata;
                3'd1: r1 <= wdata;
                3'd2: r2 <= wdata;
                3'd3: r3 <= wdata;
                3'd4: r4 <= wdata;
                3'd5: r5 <= wdata;
                3'd6: r6 <= wdata;
                default: r7 <= wdata;
            endcase
        end
    end

    function automatic logic [WordW-1:0] sel(input logic [RegAw-1:0] a,
                                             input logic [WordW-1:0] v0, input logic [WordW-1:0] v1,
                                             input logic [WordW-1:0] v2, input logic [WordW-1:0] v3,
                                             input logic [WordW-1:0] v4, input logic [WordW-1:0] v5,
                                             input logic [WordW-1:0] v6, input logic [WordW-1:0] v7);
        case (a)
            3'd0: return v0;
            3'd1: return v1;
            3'd2: return v2;
            3'd3: return v3;
            3'd4: return v4;
            3'd5: return v5;
            3'd6: return v6;
            default: return v7;
        endcase
    endfunction

    always_comb begin
        rdata_a = sel(raddr_a, r0, r1, r2, r3, r4, r5, r6, r7);
        rdata_b = sel(raddr_b, r0, r1, r2, r3, r4, r5, r6, r7);
    end

endmodule

// File: rtl/proc_core16.sv
// Multi-cycle 16-bit core: FETCH/DECODE/EXEC(/MEM) sequencing over a shared
// synchronous two-port RAM, with NZCV flags and an 8-entry register file.
module proc_core16
    import proc16_pkg::*;
#(
    parameter int unsigned AW = PcW,
    parameter int unsigned DW = WordW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [DW-1:0] data_in,
    input  logic [DW-1:0] data_ram_dout,
    output logic [DW-1:0] result,
    output logic          zero,
    output logic          negative,
    output logic          overflow,
    output logic          carry,
    output logic [AW-1:0] pc,
    output logic          prog_ram_read_en,
    output logic          data_ram_read_en,
    output logic          write_ram_en,
    output logic [DW-1:0] data_ram_din,
    output logic [AW-1:0] data_ram_addr
);

    state_e        state_q, state_d;
    logic [DW-1:0] ir_q, ir_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [DW-1:0] result_q, result_d;
    logic          n_q, z_q, c_q, v_q;
    logic          n_d, z_d, c_d, v_d;

    logic [3:0]       op;
    logic [RegAw-1:0] rd;
    logic [DW-1:0]    rs_data, rb_data;
    logic             rf_we;
    logic [RegAw-1:0] rf_waddr;
    logic [DW-1:0]    rf_wdata;
    alu_out_t         alu;

    assign op = ir_op(ir_q);
    assign rd = ir_rd(ir_q);

    // Port B doubles as the store-data read of rd for ST.
    reg_file_8x16 reg_file_8x16_1 (
        .clk     (clk),
        .rst_n   (rst_n),
        .raddr_a (ir_rs(ir_q)),
        .raddr_b ((op == OpSt) ? rd : ir_rt(ir_q)),
        .rdata_a (rs_data),
        .rdata_b (rb_data),
        .we      (rf_we),
        .waddr   (rf_waddr),
        .wdata   (rf_wdata)
    );

    assign alu = alu_exec(op, rs_data, rb_data);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            ir_q     <= '0;
            pc_q     <= '0;
            result_q <= '0;
            n_q      <= 1'b0;
            z_q      <= 1'b0;
            c_q      <= 1'b0;
            v_q      <= 1'b0;
        end else begin
            state_q  <= state_d;
            ir_q     <= ir_d;
            pc_q     <= pc_d;
            result_q <= result_d;
            n_q      <= n_d;
            z_q      <= z_d;
            c_q      <= c_d;
            v_q      <= v_d;
        end
    end

    always_comb begin
        state_d          = state_q;
        ir_d             = ir_q;
        pc_d             = pc_q;
        result_d         = result_q;
        n_d              = n_q;
        z_d              = z_q;
        c_d              = c_q;
        v_d              = v_q;
        rf_we            = 1'b0;
        rf_waddr         = rd;
        rf_wdata         = alu.res;
        prog_ram_read_en = 1'b0;
        data_ram_read_en = 1'b0;
        write_ram_en     = 1'b0;
        data_ram_din     = '0;
        data_ram_addr    = '0;

        case (state_q)
            StIdle: begin
                if (start) state_d = StFetch;
            end
            StFetch: begin
                prog_ram_read_en = 1'b1;
                state_d          = StDecode;
            end
            StDecode: begin
                ir_d    = data_in;
                state_d = StExec;
            end
            StExec: begin
                pc_d    = pc_q + AW'(1);
                state_d = StFetch;
                if (is_alu_op(op)) begin
                    rf_we    = 1'b1;
                    result_d = alu.res;
                    n_d      = alu.n;
                    z_d      = alu.z;
                    c_d      = alu.c;
                    v_d      = alu.v;
                end
                case (op)
                    OpLdi: begin
                        rf_we    = 1'b1;
                        rf_wdata = ir_imm9_sext(ir_q);
                        result_d = ir_imm9_sext(ir_q);
                    end
                    OpLd: begin
                        data_ram_read_en = 1'b1;
                        data_ram_addr    = rs_data[AW-1:0];
                        state_d          = StMem;
                    end
                    OpSt: begin
                        write_ram_en  = 1'b1;
                        data_ram_addr = rs_data[AW-1:0];
                        data_ram_din  = rb_data;
                    end
                    OpJmp: pc_d = ir_tgt(ir_q);
                    OpBz:  if (z_q)  pc_d = ir_tgt(ir_q);
                    OpBnz: if (!z_q) pc_d = ir_tgt(ir_q);
                    OpHalt: begin
                        pc_d    = pc_q;
                        state_d = StHalted;
                    end
                    default: ;
                endcase
            end
            StMem: begin
                rf_we    = 1'b1;
                rf_wdata = data_ram_dout;
                result_d = data_ram_dout;
                state_d  = StFetch;
            end
            StHalted: state_d = StHalted;
            default:  state_d = StIdle;
        endcase
    end

    assign result   = result_q;
    assign zero     = z_q;
    assign negative = n_q;
    assign overflow = v_q;
    assign carry    = c_q;
    assign pc       = pc_q;

endmodule

// File: tb/tb_proc_core16.sv
// Scoreboard bench for proc_core16 with a behavioural 2-port 16x128 RAM.
module tb_proc_core16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] data_in, data_ram_dout;
    logic [15:0] result, data_ram_din;
    logic        zero, negative, overflow, carry;
    logic [6:0]  pc, data_ram_addr;
    logic        prog_ram_read_en, data_ram_read_en, write_ram_en;

    logic        load_we;
    logic [6:0]  load_addr;
    logic [15:0] load_data;
    logic [15:0] mem [0:127];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int last_fetch_cyc = 0;

    typedef struct {
        logic [6:0]  pc;
        int          gap;
        logic [15:0] res;
        logic [3:0]  nzcv;
    } fetch_t;
    typedef struct {
        logic [6:0]  addr;
        logic [15:0] din;
    } store_t;

    fetch_t     fq[$];
    store_t     sq[$];
    logic [6:0] lq[$];

    fetch_t     fe;
    store_t     se;
    logic [6:0] le;
    int         n_en;

    proc_core16 dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .start            (start),
        .data_in          (data_in),
        .data_ram_dout    (data_ram_dout),
        .result           (result),
        .zero             (zero),
        .negative         (negative),
        .overflow         (overflow),
        .carry            (carry),
        .pc               (pc),
        .prog_ram_read_en (prog_ram_read_en),
        .data_ram_read_en (data_ram_read_en),
        .write_ram_en     (write_ram_en),
        .data_ram_din     (data_ram_din),
        .data_ram_addr    (data_ram_addr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (load_we) mem[load_addr] <= load_data;
        if (prog_ram_read_en) data_in <= mem[pc];
        if (write_ram_en) mem[data_ram_addr] <= data_ram_din;
        if (data_ram_read_en) data_ram_dout <= mem[data_ram_addr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name);
        total++;
        bad++;
        $display("FAIL %s: got event expected none", name);
    endtask

    // Monitor: pops the scoreboard whenever the core presents a RAM access.
    always @(negedge clk) begin
        if (rst_n) begin
            n_en = int'(prog_ram_read_en) + int'(data_ram_read_en) + int'(write_ram_en);
            if (n_en != 0) check("enable_onehot", 32'(n_en), 32'd1);
            if (prog_ram_read_en) begin
                if (fq.size() == 0) unexpected("fetch");
                else begin
                    fe = fq.pop_front();
                    check("fetch_pc", 32'(pc), 32'(fe.pc));
                    if (fe.gap != 0) check("fetch_gap", 32'(cyc - last_fetch_cyc), 32'(fe.gap));
                    check("fetch_result", 32'(result), 32'(fe.res));
                    check("fetch_nzcv", 32'({negative, zero, carry, overflow}), 32'(fe.nzcv));
                end
                last_fetch_cyc = cyc;
            end
            if (write_ram_en) begin
                if (sq.size() == 0) unexpected("store");
                else begin
                    se = sq.pop_front();
                    check("store_addr", 32'(data_ram_addr), 32'(se.addr));
                    check("store_din", 32'(data_ram_din), 32'(se.din));
                end
            end
            if (data_ram_read_en) begin
                if (lq.size() == 0) unexpected("load");
                else begin
                    le = lq.pop_front();
                    check("load_addr", 32'(data_ram_addr), 32'(le));
                end
            end
        end
    end

    task automatic push_fetch(input int p, input int gap, input logic [15:0] res,
                              input logic [3:0] nzcv);
        fetch_t f;
        f.pc   = 7'(p);
        f.gap  = gap;
        f.res  = res;
        f.nzcv = nzcv;
        fq.push_back(f);
    endtask

    task automatic load_word(input int a, input logic [15:0] d);
        @(negedge clk);
        load_we   = 1'b1;
        load_addr = 7'(a);
        load_data = d;
        @(negedge clk);
        load_we   = 1'b0;
    endtask

    task automatic check_outputs_zero(input string name);
        check(name, {result, pc, zero, negative, overflow, carry, prog_ram_read_en},
              32'd0);
        check({name, "_ram"}, {data_ram_din, data_ram_addr, data_ram_read_en, write_ram_en},
              32'd0);
    endtask

    logic [15:0] prog [0:36];
    store_t      st_exp;
    bit          seen;

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        load_we   = 1'b0;
        load_addr = '0;
        load_data = '0;

        for (int i = 0; i <= 36; i++) prog[i] = 16'h0000;
        prog[3]  = 16'h9205;  // LDI r1,5
        prog[4]  = 16'h95FD;  // LDI r2,-3
        prog[5]  = 16'h1650;  // ADD r3,r1,r2
        prog[6]  = 16'hC00A;  // JMP 10
        prog[9]  = 16'hF000;  // HALT
        prog[10] = 16'h92FF;  // LDI r1,0x0FF
        prog[11] = 16'h2848;  // SUB r4,r1,r1
        prog[12] = 16'h9A01;  // LDI r5,1
        for (int i = 13; i <= 27; i++) prog[i] = 16'h7B40;  // SHL r5,r5
        prog[28] = 16'h9E64;  // LDI r7,100
        prog[29] = 16'hB7C0;  // ST r3,[r7]
        prog[30] = 16'hADC0;  // LD r6,[r7]
        prog[31] = 16'h2048;  // SUB r0,r1,r1
        prog[32] = 16'hD022;  // BZ 34
        prog[33] = 16'h91AA;  // LDI r0,0x1AA (skipped)
        prog[34] = 16'hE028;  // BNZ 40 (not taken)
        prog[35] = 16'h9407;  // LDI r2,7
        prog[36] = 16'hC009;  // JMP 9
        for (int i = 0; i <= 36; i++) load_word(i, prog[i]);

        @(negedge clk);
        check_outputs_zero("reset_state");

        push_fetch(0, 0, 16'h0000, 4'b0000);
        push_fetch(1, 3, 16'h0000, 4'b0000);
        push_fetch(2, 3, 16'h0000, 4'b0000);
        push_fetch(3, 3, 16'h0000, 4'b0000);
        push_fetch(4, 3, 16'h0005, 4'b0000);
        push_fetch(5, 3, 16'hFFFD, 4'b0000);
        push_fetch(6, 3, 16'h0002, 4'b0010);
        push_fetch(10, 3, 16'h0002, 4'b0010);
        push_fetch(11, 3, 16'h00FF, 4'b0010);
        push_fetch(12, 3, 16'h0000, 4'b0110);
        push_fetch(13, 3, 16'h0001, 4'b0110);
        for (int i = 1; i <= 15; i++)
            push_fetch(13 + i, 3, 16'(32'd1 << i), (i == 15) ? 4'b1000 : 4'b0000);
        push_fetch(29, 3, 16'd100, 4'b1000);
        st_exp.addr = 7'd100;
        st_exp.din  = 16'h0002;
        sq.push_back(st_exp);
        push_fetch(30, 3, 16'd100, 4'b1000);
        lq.push_back(7'd100);
        push_fetch(31, 4, 16'h0002, 4'b1000);
        push_fetch(32, 3, 16'h0000, 4'b0110);
        push_fetch(34, 3, 16'h0000, 4'b0110);
        push_fetch(35, 3, 16'h0000, 4'b0110);
        push_fetch(36, 3, 16'h0007, 4'b0110);
        push_fetch(9, 3, 16'h0007, 4'b0110);

        rst_n = 1'b1;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;

        for (int i = 0; i < 3000 && fq.size() != 0; i++) @(negedge clk);
        check("trace_drained", 32'(fq.size()), 32'd0);
        check("stores_drained", 32'(sq.size()), 32'd0);
        check("loads_drained", 32'(lq.size()), 32'd0);

        repeat (4) @(negedge clk);
        for (int i = 0; i < 20; i++) begin
            check("halt_pc", 32'(pc), 32'd9);
            check("halt_enables", {prog_ram_read_en, data_ram_read_en, write_ram_en}, 32'd0);
            @(negedge clk);
        end

        check("r0", 32'(dut.reg_file_8x16_1.r0), 32'h0000);
        check("r1", 32'(dut.reg_file_8x16_1.r1), 32'h00FF);
        check("r2", 32'(dut.reg_file_8x16_1.r2), 32'h0007);
        check("r3", 32'(dut.reg_file_8x16_1.r3), 32'h0002);
        check("r4", 32'(dut.reg_file_8x16_1.r4), 32'h0000);
        check("r5", 32'(dut.reg_file_8x16_1.r5), 32'h8000);
        check("r6", 32'(dut.reg_file_8x16_1.r6), 32'h0002);
        check("r7", 32'(dut.reg_file_8x16_1.r7), 32'd100);
        check("mem100", 32'(mem[100]), 32'h0002);

        // Reset abort during a load: r7 is 0 after reset, so LD r6,[r7] reads address 0.
        load_word(0, 16'hADC0);
        rst_n = 1'b0;
        @(negedge clk);
        check_outputs_zero("reset_after_halt");
        push_fetch(0, 0, 16'h0000, 4'b0000);
        lq.push_back(7'd0);
        rst_n = 1'b1;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (data_ram_read_en) seen = 1'b1;
        end
        check("ld_reached", 32'(seen), 32'd1);
        #1 rst_n = 1'b0;
        #1 check_outputs_zero("abort_mid_ld");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("abort_no_write", 32'(write_ram_en), 32'd0);
        end
        check("abort_r6", 32'(dut.reg_file_8x16_1.r6), 32'h0000);
        check("abort_queues", 32'(fq.size() + lq.size() + sq.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
